// File: rtl/interrupt_ctrl_if.sv
// ---------------------------------------------------------------------------
// interrupt_ctrl_if : event-source and CPU-side signal bundle of interrupt_ctrl
// Rev 1.0 -- lost_cnt member present only with INT_LOST_CNT_EN
// ---------------------------------------------------------------------------
`default_nettype none

interface interrupt_ctrl_if #(
    parameter int TMR_W = 16
);
    logic [6:0]       ext_irq;
    logic [7:0]       mask;
    logic             tmr_en;
    logic [TMR_W-1:0] tmr_load;
    logic [15:0]      direcciones;
    logic [7:0]       int_e;
    logic [7:0]       pending;
    logic             tmr_tick;
`ifdef INT_LOST_CNT_EN
    logic [7:0]       lost_cnt;

    modport master (
        output ext_irq, mask, tmr_en, tmr_load, direcciones,
        input  int_e, pending, tmr_tick, lost_cnt
    );
    modport slave (
        input  ext_irq, mask, tmr_en, tmr_load, direcciones,
        output int_e, pending, tmr_tick, lost_cnt
    );
`else
    modport master (
        output ext_irq, mask, tmr_en, tmr_load, direcciones,
        input  int_e, pending, tmr_tick
    );
    modport slave (
        input  ext_irq, mask, tmr_en, tmr_load, direcciones,
        output int_e, pending, tmr_tick
    );
`endif
endinterface

`default_nettype wire

// File: rtl/interrupt_ctrl.sv
// ---------------------------------------------------------------------------
// interrupt_ctrl : 8-source interrupt controller (source 0 = timer, 1..7 ext)
// Rev 1.0 -- optional lost-event counter enabled by INT_LOST_CNT_EN
// ---------------------------------------------------------------------------
`default_nettype none

module interrupt_ctrl #(
    parameter int          TMR_W    = 16,
    parameter logic [15:0] VEC_BASE = 16'hFFF0
) (
    input  logic             clk,
    input  logic             reset,
    interrupt_ctrl_if.slave  bus
);

    logic [6:0]       r_s1;
    logic [6:0]       r_s2;
    logic [6:0]       r_s3;
    logic [6:0]       w_rise;
    logic [TMR_W-1:0] r_cnt;
    logic             w_expire;
    logic             r_tick;
    logic [7:0]       w_set;
    logic [7:0]       w_ack;
    logic [7:0]       r_pend;

    // External lines: 2-FF synchroniser followed by a history flop for edge detect
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_s3 <= '0;
        end else begin
            r_s1 <= bus.ext_irq;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_rise   = r_s2 & ~r_s3;
    assign w_expire = bus.tmr_en && (bus.tmr_load != '0) && (r_cnt <= TMR_W'(1));

    // Expiry at cnt<=1 and reload to tmr_load gives a period of exactly tmr_load
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_expire;
            if (!bus.tmr_en || w_expire) begin
                r_cnt <= bus.tmr_load;
            end else if (bus.tmr_load != '0) begin
                r_cnt <= r_cnt - TMR_W'(1);
            end
        end
    end

    for (genvar i = 0; i < 8; i++) begin : g_ack
        localparam logic [15:0] c_vec = VEC_BASE + 16'(i);
        assign w_ack[i] = (bus.direcciones == c_vec);
    end

    assign w_set = {w_rise, w_expire};

    // A new event in the same cycle as its acknowledge keeps the bit set
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend <= '0;
        end else begin
            r_pend <= (r_pend & ~w_ack) | w_set;
        end
    end

    assign bus.pending  = r_pend;
    assign bus.int_e    = r_pend & bus.mask;
    assign bus.tmr_tick = r_tick;

`ifdef INT_LOST_CNT_EN
    localparam logic [15:0] c_lost_clr = VEC_BASE + 16'd8;

    logic       w_lost_hit;
    logic       w_lost_clr;
    logic [7:0] r_lost;

    assign w_lost_hit = |(w_set & r_pend & ~w_ack);
    assign w_lost_clr = (bus.direcciones == c_lost_clr);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lost <= '0;
        end else if (w_lost_clr) begin
            r_lost <= '0;
        end else if (w_lost_hit && (r_lost != 8'hFF)) begin
            r_lost <= r_lost + 8'd1;
        end
    end

    assign bus.lost_cnt = r_lost;
`endif

endmodule

`default_nettype wire

// File: tb/tb_interrupt_ctrl.sv
// ---------------------------------------------------------------------------
// tb_interrupt_ctrl : scoreboard bench for interrupt_ctrl with reference model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_interrupt_ctrl;

    localparam logic [15:0] VEC = 16'hFFF0;

    typedef struct {
        logic [7:0] pend;
        logic [7:0] inte;
        logic       tick;
        logic [7:0] lost;
    } exp_t;

    logic clk;
    logic reset;

    interrupt_ctrl_if #(.TMR_W(16)) bus ();

    interrupt_ctrl #(.TMR_W(16), .VEC_BASE(VEC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int tick_seen = 0;

    exp_t sb[$];

    // reference model state
    logic [7:0] m_pend;
    logic [7:0] m_lost;
    logic [6:0] hist[$];
    longint     m_e;
    longint     m_dead;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = '0;
        m_lost = '0;
        hist   = '{7'd0, 7'd0, 7'd0, 7'd0};
        m_dead = m_e;
    endtask

    // One clock edge of the specified behaviour, using the inputs now on the bus
    task automatic model_edge();
        logic [6:0] rise;
        logic       tick;
        logic [7:0] set;
        logic [7:0] ack;
        int         d;
        exp_t       x;
        m_e++;
        hist.push_front(bus.ext_irq);
        if (hist.size() > 4) void'(hist.pop_back());
        rise = hist[2] & ~hist[3];
        tick = 1'b0;
        if (!bus.tmr_en) begin
            m_dead = m_e + longint'(bus.tmr_load);
        end else if (bus.tmr_load == 16'd0) begin
            m_dead++;
        end else if (m_e >= m_dead) begin
            tick   = 1'b1;
            m_dead = m_e + longint'(bus.tmr_load);
        end
        set = {rise, tick};
        ack = '0;
        d = int'(bus.direcciones) - int'(VEC);
        if (d >= 0 && d <= 7) ack[d] = 1'b1;
        if (d == 8) m_lost = '0;
        else if (((set & m_pend & ~ack) != 8'd0) && m_lost != 8'hFF) m_lost = m_lost + 8'd1;
        m_pend = (m_pend & ~ack) | set;
        x.pend = m_pend;
        x.inte = m_pend & bus.mask;
        x.tick = tick;
        x.lost = m_lost;
        sb.push_back(x);
    endtask

    // Inputs are set by the caller at a falling edge; step covers one rising edge
    task automatic step();
        #1;
        chk("int_e_comb", {24'd0, bus.int_e}, {24'd0, m_pend & bus.mask});
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        #3;
        reset = 1'b0;
        #1;
        chk("rst_int_e",   {24'd0, bus.int_e},   32'd0);
        chk("rst_pending", {24'd0, bus.pending}, 32'd0);
        chk("rst_tick",    {31'd0, bus.tmr_tick}, 32'd0);
`ifdef INT_LOST_CNT_EN
        chk("rst_lost",    {24'd0, bus.lost_cnt}, 32'd0);
`endif
        sb.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    task automatic set_in(input logic [6:0] e, input logic [7:0] m, input logic en,
                          input logic [15:0] ld, input logic [15:0] a);
        bus.ext_irq     = e;
        bus.mask        = m;
        bus.tmr_en      = en;
        bus.tmr_load    = ld;
        bus.direcciones = a;
    endtask

    // scoreboard monitor
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (bus.tmr_tick === 1'b1) tick_seen++;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                chk("pending",  {24'd0, bus.pending},  {24'd0, x.pend});
                chk("int_e",    {24'd0, bus.int_e},    {24'd0, x.inte});
                chk("tmr_tick", {31'd0, bus.tmr_tick}, {31'd0, x.tick});
`ifdef INT_LOST_CNT_EN
                chk("lost_cnt", {24'd0, bus.lost_cnt}, {24'd0, x.lost});
`endif
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int guard;
        logic [6:0] e;
        m_e = 0;
        model_reset();
        reset = 1'b0;
        set_in(7'd0, 8'hFF, 1'b0, 16'd0, 16'd0);
        #1;
        chk("init_int_e",   {24'd0, bus.int_e},    32'd0);
        chk("init_pending", {24'd0, bus.pending},  32'd0);
        chk("init_tick",    {31'd0, bus.tmr_tick}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // source 4 edge, long hold, acknowledge, no re-trigger
        set_in(7'h08, 8'hFF, 1'b0, 16'd0, 16'd0);
        repeat (22) step();
        chk("edge_int_e", {24'd0, bus.int_e}, 32'h10);
        bus.direcciones = VEC + 16'd4;
        step();
        bus.direcciones = 16'd0;
        repeat (5) step();
        chk("edge_no_retrig", {24'd0, bus.pending}, 32'd0);
        bus.ext_irq = 7'd0;
        repeat (4) step();

        // timer period 5 then tmr_load=0
        set_in(7'd0, 8'hFF, 1'b1, 16'd5, 16'd0);
        t0 = tick_seen;
        repeat (30) step();
        chk("tmr5_ticks", tick_seen - t0, 32'd6);
        chk("tmr5_pend0", {31'd0, bus.pending[0]}, 32'd1);
        bus.tmr_load = 16'd0;
        t0 = tick_seen;
        repeat (100) step();
        chk("tmr0_ticks", tick_seen - t0, 32'd0);

        // acknowledge colliding with a tick on an already pending bit
        bus.tmr_load = 16'd5;
        guard = 0;
        while (!(m_dead == m_e + 1 && m_pend[0]) && guard < 50) begin
            step();
            guard++;
        end
        chk("collide_found", guard < 50, 32'd1);
        bus.direcciones = VEC;
        step();
        chk("collide_keep", {31'd0, bus.pending[0]}, 32'd1);
        bus.direcciones = 16'd0;
        step();
        bus.direcciones = VEC;
        step();
        chk("collide_ack", {31'd0, bus.pending[0]}, 32'd0);

        // masking keeps pending; unmasking shows it combinationally
        set_in(7'd0, 8'hFF, 1'b0, 16'd0, 16'd0);
        for (int i = 0; i < 8; i++) begin
            bus.direcciones = VEC + 16'(i);
            step();
        end
        set_in(7'h01, 8'h00, 1'b0, 16'd0, 16'd0);
        repeat (4) step();
        chk("mask_pend", {24'd0, bus.pending}, 32'h02);
        chk("mask_int_e", {24'd0, bus.int_e}, 32'h00);
        bus.mask = 8'h02;
        #1;
        chk("unmask_int_e", {24'd0, bus.int_e}, 32'h02);
        step();

        // source 2 overrun, clear, then saturation through the timer
        set_in(7'd0, 8'hFF, 1'b0, 16'd0, 16'd0);
        repeat (3) step();
        for (int k = 0; k < 4; k++) begin
            bus.ext_irq = 7'h02;
            repeat (3) step();
            bus.ext_irq = 7'h00;
            repeat (3) step();
        end
`ifdef INT_LOST_CNT_EN
        chk("lost_3", {24'd0, bus.lost_cnt}, 32'd3);
`endif
        bus.direcciones = VEC + 16'd8;
        step();
        bus.direcciones = 16'd0;
`ifdef INT_LOST_CNT_EN
        chk("lost_clr", {24'd0, bus.lost_cnt}, 32'd0);
`endif
        set_in(7'd0, 8'hFF, 1'b1, 16'd1, 16'd0);
        repeat (300) step();
`ifdef INT_LOST_CNT_EN
        chk("lost_sat", {24'd0, bus.lost_cnt}, 32'hFF);
`endif

        // fill all pending, then reset mid-count
        bus.ext_irq = 7'h7F;
        repeat (4) step();
        chk("all_pend", {24'd0, bus.pending}, 32'hFF);
        do_reset();

        // randomized run with occasional mid-cycle resets
        e = 7'd0;
        for (int i = 0; i < 2000; i++) begin
            if (i % 700 == 350) do_reset();
            e = e ^ (7'($urandom) & 7'($urandom));
            bus.ext_irq  = e;
            bus.mask     = 8'($urandom);
            bus.tmr_en   = ($urandom_range(0, 7) != 0);
            bus.tmr_load = 16'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) bus.direcciones = VEC + 16'($urandom_range(0, 8));
            else bus.direcciones = 16'($urandom);
            step();
        end

        @(negedge clk);
        chk("sb_drain", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
